phaser_out_tap_ctrl: RTL and testbench
======================================

PHASER_OUT_TAP_CTRL -- requirements
Module: phaser_out_tap_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 8, giving wait cycles after each tap step (legal 1..255).
REQ-002 The block SHALL have parameter COARSE_INIT, default 0, giving the coarse tap count after reset (0..63).
REQ-003 The block SHALL have parameter FINE_INIT, default 0, giving the fine tap count after reset (0..63).
REQ-004 Clocking SHALL be one clock, SYSCLK; reset RST_N SHALL be asynchronous and active-low.
REQ-005 SYSCLK  in  1  sole clock, rising edge.
REQ-006 RST_N  in  1  asynchronous active-low reset.
REQ-007 REQ_VALID  in  1  new tap target request.
REQ-008 REQ_READY  out  1  controller idle, request accepted on VALID&READY.
REQ-009 REQ_COARSE  in  6  target coarse tap.
REQ-010 REQ_FINE  in  6  target fine tap.
REQ-011 COARSEENABLE  out  1  coarse step strobe to phaser.
REQ-012 COARSEINC  out  1  coarse direction, 1 = increment.
REQ-013 FINEENABLE  out  1  fine step strobe to phaser.
REQ-014 FINEINC  out  1  fine direction, 1 = increment.
REQ-015 COARSEOVERFLOW  in  1  coarse overflow flag from phaser.
REQ-016 FINEOVERFLOW  in  1  fine overflow flag from phaser.
REQ-017 CUR_COARSE  out  6  tracked current coarse tap.
REQ-018 CUR_FINE  out  6  tracked current fine tap.
REQ-019 DONE  out  1  one-cycle pulse, request finished.
REQ-020 ERR  out  1  sticky: last request aborted on overflow.

Function
REQ-021 FSM states SHALL be IDLE, CHECK, C_STEP, F_STEP, WAIT, FIN.
REQ-022 REQ_READY SHALL be 1 only in IDLE; acceptance latches REQ_COARSE/REQ_FINE, clears ERR, moves to CHECK.
REQ-023 CHECK SHALL go to C_STEP if CUR_COARSE != target, else F_STEP if CUR_FINE != target, else FIN (coarse always converges first).
REQ-024 C_STEP/F_STEP SHALL last one cycle with the matching ENABLE = 1 and INC = (current < target); the tracked count changes by +-1 at that cycle's end; then WAIT.
REQ-025 WAIT SHALL last exactly SETTLE_CYCLES cycles, then return to CHECK; all ENABLE outputs SHALL be 0 outside step states.
REQ-026 Latency: DONE SHALL be high in cycle N*(SETTLE_CYCLES+2)+2 after the acceptance edge, N = |dCoarse|+|dFine|; zero-delta request gives DONE in cycle 2.
REQ-027 FIN SHALL assert DONE for one cycle and return to IDLE.
REQ-028 In WAIT following a coarse (fine) step, COARSEOVERFLOW (FINEOVERFLOW) high SHALL abort: ERR = 1, go to FIN; the tracked count keeps the stepped value.
REQ-029 Tracked counts SHALL never wrap: a step beyond 0 or 63 is impossible because targets are 6-bit; an overflow flag outside WAIT SHALL be ignored.
REQ-030 REQ_VALID while not ready SHALL be ignored (no queueing); requester holds VALID until READY.

Reset
REQ-031 During RST_N = 0, all ENABLE/INC outputs, DONE, ERR and REQ_READY SHALL be 0, CUR_COARSE = COARSE_INIT, CUR_FINE = FINE_INIT, FSM = IDLE; REQ_READY = 1 in the first cycle after release.
REQ-032 Reset asserted mid-operation SHALL abort immediately (asynchronously drop strobes), with no DONE pulse.

Structure
REQ-033 Package phaser_out_tap_pkg SHALL hold the FSM state typedef, TAP_W = 6, TAP_MAX = 63 and the settle-counter width (8).
REQ-034 The block SHALL be one flat module; no sub-module is required.

Verification
REQ-035 SETTLE_CYCLES = 4, request coarse 2 / fine 1 from 0/0 -> two COARSEINC=1 strobes then one FINEINC=1 strobe, 6 cycles apart; DONE in cycle 20; CUR = 2/1.
REQ-036 From 2/1, request 0/3 -> two coarse decrement strobes (COARSEINC=0), then two fine increment strobes; DONE in cycle 26.
REQ-037 Request equal to current -> no strobes, DONE in cycle 2, ERR = 0.
REQ-038 FINEOVERFLOW raised in WAIT after the first fine step of a 0->5 fine request -> ERR = 1, DONE pulses, CUR_FINE = 1, next accepted request clears ERR.
REQ-039 RST_N low in a C_STEP cycle -> COARSEENABLE drops without waiting for a clock edge, CUR_* = INIT values, no DONE; REQ_READY = 1 after release.
REQ-040 REQ_VALID pulsed while busy -> ignored; CUR_* and DONE timing unchanged.

Source files
------------

// File: rtl/phaser_out_tap_pkg.sv
// Shared types and constants for the phaser output tap controller.
// Holds the FSM state encoding, tap range and the saturating step helper.
package phaser_out_tap_pkg;

    localparam int TAP_W    = 6;
    localparam int SETTLE_W = 8;

    localparam logic [TAP_W-1:0] TAP_MAX  = 6'd63;
    localparam logic [TAP_W-1:0] TAP_ZERO = 6'd0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_C_STEP = 3'd2,
        ST_F_STEP = 3'd3,
        ST_WAIT   = 3'd4,
        ST_FIN    = 3'd5
    } tap_state_e;

    // Saturating +-1, so a corrupted target can never wrap the tracked count
    function automatic logic [TAP_W-1:0] tap_step(input logic [TAP_W-1:0] cur,
                                                  input logic             inc);
        logic [TAP_W-1:0] res;
        if (inc) begin
            res = (cur == TAP_MAX) ? cur : cur + 6'd1;
        end else begin
            res = (cur == TAP_ZERO) ? cur : cur - 6'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/phaser_out_tap_ctrl.sv
// Walks the phaser coarse/fine taps one step at a time towards a requested
// target, waiting SETTLE_CYCLES after every step and aborting on overflow.
module phaser_out_tap_ctrl
    import phaser_out_tap_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int COARSE_INIT   = 0,
    parameter int FINE_INIT     = 0
) (
    input  logic             SYSCLK,
    input  logic             RST_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [TAP_W-1:0] REQ_COARSE,
    input  logic [TAP_W-1:0] REQ_FINE,
    output logic             COARSEENABLE,
    output logic             COARSEINC,
    output logic             FINEENABLE,
    output logic             FINEINC,
    input  logic             COARSEOVERFLOW,
    input  logic             FINEOVERFLOW,
    output logic [TAP_W-1:0] CUR_COARSE,
    output logic [TAP_W-1:0] CUR_FINE,
    output logic             DONE,
    output logic             ERR
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST   = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TAP_W-1:0]    COARSE_INIT_V = TAP_W'(COARSE_INIT);
    localparam logic [TAP_W-1:0]    FINE_INIT_V   = TAP_W'(FINE_INIT);

    tap_state_e          state_r, state_s;
    logic                accept_s, abort_s;
    logic [TAP_W-1:0]    tgt_coarse_r, tgt_fine_r;
    logic [TAP_W-1:0]    cur_coarse_r, cur_fine_r;
    logic [SETTLE_W-1:0] settle_cnt_r;
    logic                step_coarse_r;
    logic                ready_r, done_r, err_r;
    logic                cen_r, cinc_r, fen_r, finc_r;

    // Next-state decode; coarse converges before fine is touched
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (REQ_VALID && ready_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_CHECK;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (cur_coarse_r != tgt_coarse_r) begin
                    state_s = ST_C_STEP;
                end else if (cur_fine_r != tgt_fine_r) begin
                    state_s = ST_F_STEP;
                end else begin
                    state_s = ST_FIN;
                end
            end
            ST_C_STEP: state_s = ST_WAIT;
            ST_F_STEP: state_s = ST_WAIT;
            ST_WAIT: begin
                // Only the overflow flag of the axis just stepped is meaningful
                if (step_coarse_r ? COARSEOVERFLOW : FINEOVERFLOW) begin
                    abort_s = 1'b1;
                    state_s = ST_FIN;
                end else if (settle_cnt_r == SETTLE_LAST) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and registered status/strobe outputs
    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
            cen_r   <= 1'b0;
            cinc_r  <= 1'b0;
            fen_r   <= 1'b0;
            finc_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == ST_IDLE);
            done_r  <= (state_s == ST_FIN);
            cen_r   <= (state_s == ST_C_STEP);
            cinc_r  <= (state_s == ST_C_STEP) && (cur_coarse_r < tgt_coarse_r);
            fen_r   <= (state_s == ST_F_STEP);
            finc_r  <= (state_s == ST_F_STEP) && (cur_fine_r < tgt_fine_r);
        end
    end

    // Target latch, sticky error and tracked tap counts
    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            tgt_coarse_r  <= COARSE_INIT_V;
            tgt_fine_r    <= FINE_INIT_V;
            cur_coarse_r  <= COARSE_INIT_V;
            cur_fine_r    <= FINE_INIT_V;
            err_r         <= 1'b0;
            step_coarse_r <= 1'b0;
        end else begin
            if (accept_s) begin
                tgt_coarse_r <= REQ_COARSE;
                tgt_fine_r   <= REQ_FINE;
                err_r        <= 1'b0;
            end else if (abort_s) begin
                err_r        <= 1'b1;
            end
            if (state_r == ST_C_STEP) begin
                cur_coarse_r  <= tap_step(cur_coarse_r, cinc_r);
                step_coarse_r <= 1'b1;
            end else if (state_r == ST_F_STEP) begin
                cur_fine_r    <= tap_step(cur_fine_r, finc_r);
                step_coarse_r <= 1'b0;
            end
        end
    end

    // Settle counter runs only while in WAIT and restarts on every entry
    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            settle_cnt_r <= 8'd0;
        end else if (state_r == ST_WAIT) begin
            settle_cnt_r <= settle_cnt_r + 8'd1;
        end else begin
            settle_cnt_r <= 8'd0;
        end
    end

    assign REQ_READY    = ready_r;
    assign DONE         = done_r;
    assign ERR          = err_r;
    assign COARSEENABLE = cen_r;
    assign COARSEINC    = cinc_r;
    assign FINEENABLE   = fen_r;
    assign FINEINC      = finc_r;
    assign CUR_COARSE   = cur_coarse_r;
    assign CUR_FINE     = cur_fine_r;

endmodule

// File: tb/tb_phaser_out_tap_ctrl.sv
// Directed bench for phaser_out_tap_ctrl with SETTLE_CYCLES = 4; every step
// therefore costs 6 cycles and DONE lands in cycle 6*N+2 after acceptance.
module tb_phaser_out_tap_ctrl;

    logic       SYSCLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [5:0] REQ_COARSE = 6'd0;
    logic [5:0] REQ_FINE = 6'd0;
    logic       COARSEENABLE, COARSEINC, FINEENABLE, FINEINC;
    logic       COARSEOVERFLOW = 1'b0;
    logic       FINEOVERFLOW = 1'b0;
    logic [5:0] CUR_COARSE, CUR_FINE;
    logic       DONE, ERR;

    int n_vec  = 0;
    int n_miss = 0;

    int s_n;
    int s_cyc  [16];
    bit s_fine [16];
    bit s_inc  [16];
    int done_cyc;

    always #5 SYSCLK = ~SYSCLK;

    phaser_out_tap_ctrl #(
        .SETTLE_CYCLES(4),
        .COARSE_INIT  (0),
        .FINE_INIT    (0)
    ) dut (
        .SYSCLK        (SYSCLK),
        .RST_N         (RST_N),
        .REQ_VALID     (REQ_VALID),
        .REQ_READY     (REQ_READY),
        .REQ_COARSE    (REQ_COARSE),
        .REQ_FINE      (REQ_FINE),
        .COARSEENABLE  (COARSEENABLE),
        .COARSEINC     (COARSEINC),
        .FINEENABLE    (FINEENABLE),
        .FINEINC       (FINEINC),
        .COARSEOVERFLOW(COARSEOVERFLOW),
        .FINEOVERFLOW  (FINEOVERFLOW),
        .CUR_COARSE    (CUR_COARSE),
        .CUR_FINE      (CUR_FINE),
        .DONE          (DONE),
        .ERR           (ERR)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge SYSCLK);
            if (REQ_READY) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    // Issue one request and log every strobe by cycle number after acceptance
    task automatic run_req(input string tag, input logic [5:0] c, input logic [5:0] f,
                           input int ovf_cyc, input int busy_cyc);
        wait_ready(tag);
        REQ_VALID  = 1'b1;
        REQ_COARSE = c;
        REQ_FINE   = f;
        @(posedge SYSCLK);
        #1 REQ_VALID = 1'b0;
        s_n      = 0;
        done_cyc = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge SYSCLK);
            if ((COARSEENABLE || FINEENABLE) && s_n < 16) begin
                s_cyc[s_n]  = k;
                s_fine[s_n] = FINEENABLE;
                s_inc[s_n]  = FINEENABLE ? FINEINC : COARSEINC;
                s_n++;
            end
            if (k == busy_cyc) chk({tag, "_busy_ready"}, 32'(REQ_READY), 32'd0);
            if (DONE) begin
                done_cyc = k;
                break;
            end
            FINEOVERFLOW = (k == ovf_cyc);
            REQ_VALID    = (k == busy_cyc);
            if (k == busy_cyc) begin
                REQ_COARSE = 6'd63;
                REQ_FINE   = 6'd63;
            end
        end
        FINEOVERFLOW = 1'b0;
        REQ_VALID    = 1'b0;
        if (done_cyc == 0) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic exp_strobe(input string tag, input int idx, input int cyc,
                              input bit fine, input bit inc);
        chk($sformatf("%s_s%0d_cyc", tag, idx), s_cyc[idx], cyc);
        chk($sformatf("%s_s%0d_axis", tag, idx), 32'(s_fine[idx]), 32'(fine));
        chk($sformatf("%s_s%0d_inc", tag, idx), 32'(s_inc[idx]), 32'(inc));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge SYSCLK);
        chk("rst_ready", 32'(REQ_READY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_en", 32'({COARSEENABLE, COARSEINC, FINEENABLE, FINEINC}), 32'd0);
        chk("rst_cur", 32'({CUR_COARSE, CUR_FINE}), 32'd0);
        RST_N = 1'b1;
        @(posedge SYSCLK);
        #1 chk("rel_ready", 32'(REQ_READY), 32'd1);

        // 0/0 -> 2/1
        run_req("t1", 6'd2, 6'd1, 0, 0);
        chk("t1_done", done_cyc, 20);
        chk("t1_n", s_n, 3);
        exp_strobe("t1", 0, 2, 1'b0, 1'b1);
        exp_strobe("t1", 1, 8, 1'b0, 1'b1);
        exp_strobe("t1", 2, 14, 1'b1, 1'b1);
        chk("t1_cur_c", 32'(CUR_COARSE), 32'd2);
        chk("t1_cur_f", 32'(CUR_FINE), 32'd1);
        @(negedge SYSCLK);
        chk("t1_done_pulse", 32'(DONE), 32'd0);
        chk("t1_ready_after", 32'(REQ_READY), 32'd1);

        // 2/1 -> 0/3 with a stray VALID pulse in the middle
        run_req("t2", 6'd0, 6'd3, 0, 5);
        chk("t2_done", done_cyc, 26);
        chk("t2_n", s_n, 4);
        exp_strobe("t2", 0, 2, 1'b0, 1'b0);
        exp_strobe("t2", 1, 8, 1'b0, 1'b0);
        exp_strobe("t2", 2, 14, 1'b1, 1'b1);
        exp_strobe("t2", 3, 20, 1'b1, 1'b1);
        chk("t2_cur", 32'({CUR_COARSE, CUR_FINE}), 32'({6'd0, 6'd3}));

        // Request equal to current
        run_req("t3", 6'd0, 6'd3, 0, 0);
        chk("t3_done", done_cyc, 2);
        chk("t3_n", s_n, 0);
        chk("t3_err", 32'(ERR), 32'd0);

        // 0/3 -> 0/0, overflow raised in CHECK must be ignored
        run_req("t4", 6'd0, 6'd0, 1, 0);
        chk("t4_done", done_cyc, 20);
        chk("t4_n", s_n, 3);
        exp_strobe("t4", 0, 2, 1'b1, 1'b0);
        exp_strobe("t4", 2, 14, 1'b1, 1'b0);
        chk("t4_err", 32'(ERR), 32'd0);
        chk("t4_cur_f", 32'(CUR_FINE), 32'd0);

        // 0/0 -> 0/5 aborted by FINEOVERFLOW in the first WAIT
        run_req("t5", 6'd0, 6'd5, 3, 0);
        chk("t5_done", done_cyc, 4);
        chk("t5_n", s_n, 1);
        exp_strobe("t5", 0, 2, 1'b1, 1'b1);
        chk("t5_err", 32'(ERR), 32'd1);
        chk("t5_cur_f", 32'(CUR_FINE), 32'd1);
        @(negedge SYSCLK);
        chk("t5_err_sticky", 32'(ERR), 32'd1);

        // Next accepted request clears ERR
        run_req("t6", 6'd0, 6'd1, 0, 0);
        chk("t6_done", done_cyc, 2);
        chk("t6_err", 32'(ERR), 32'd0);

        // Reset during a coarse step
        wait_ready("t7");
        REQ_VALID  = 1'b1;
        REQ_COARSE = 6'd3;
        REQ_FINE   = 6'd1;
        @(posedge SYSCLK);
        #1 REQ_VALID = 1'b0;
        repeat (2) @(negedge SYSCLK);
        chk("t7_cen_before", 32'(COARSEENABLE), 32'd1);
        #1 RST_N = 1'b0;
        #1;
        chk("t7_cen_async", 32'(COARSEENABLE), 32'd0);
        chk("t7_cur_init", 32'({CUR_COARSE, CUR_FINE}), 32'd0);
        chk("t7_done", 32'(DONE), 32'd0);
        chk("t7_ready", 32'(REQ_READY), 32'd0);
        repeat (2) @(negedge SYSCLK);
        RST_N = 1'b1;
        @(posedge SYSCLK);
        #1;
        chk("t7_ready_rel", 32'(REQ_READY), 32'd1);
        chk("t7_done_rel", 32'(DONE), 32'd0);
        chk("t7_cen_rel", 32'(COARSEENABLE), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
